instr_fetch_buffer: RTL

Instruction-side receiver for the pipeline's `instr_in` stream. It accepts 32-bit MIPS instruction words pushed by an external writer (bench, loader or boot ROM sequencer), buffers them in a FIFO, and presents them one per cycle to the IF/ID stage. It honours hazard-unit stalls and branch flushes, and tags each issued word with a sequential PC.

---
 rtl/instr_fetch_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - instruction FIFO feeding IF/ID with stall, flush and PC tagging
// Define IFB_BYPASS_EN to load a word straight into the output register when the FIFO is empty.
module instr_fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       instr_in,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  output logic [WIDTH-1:0]       instr_out,
  output logic                   instr_valid,
  output logic [31:0]            pc_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [31:0]      pc_next;
  logic             advance;
  logic             pop;
  logic             push;
  logic             bypass;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign advance = !stall && !flush;
  assign pop     = advance && !empty;
`ifdef IFB_BYPASS_EN
  assign bypass  = advance && empty && wr_en;
`else
  assign bypass  = 1'b0;
`endif
  // A full FIFO rejects the push even when a pop frees a slot on the same edge.
  assign push    = wr_en && !full && !flush && !bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
      pc_next     <= '0;
    end else if (flush) begin
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_next     <= flush_pc;
    end else if (!stall) begin
      if (pop || bypass) begin
        instr_out   <= pop ? mem[rd_ptr] : instr_in;
        instr_valid <= 1'b1;
        pc_out      <= pc_next;
        pc_next     <= pc_next + 32'd4;
      end else begin
        instr_out   <= '0;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
